// File: rtl/wb_bus_decoder.sv
// -----------------------------------------------------------------------------
// wb_bus_decoder
//
// Wishbone classic address decoder and bus watchdog for a single CPU master.
// The upper address field (adr[BASE+SELW-1:BASE]) selects one of NPORTS = 2**SELW
// slave slots. The decode is registered: the selected slave sees its strobe
// one cycle after the master raises m_stb. Cycles to unpopulated slots, cycles
// that stall longer than TIMEOUT, and cycles a slave ends with err are all
// terminated with m_err. The faulting address and a cause code are captured.
//
// Optional build macro: WB_DECODER_STATS_EN
//   When defined, an extra output err_count (16 bits) gives a saturating count
//   of terminated cycles. When undefined, the port and its counter do not exist.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   m_cyc/m_stb/m_we    master cycle, strobe, write enable
//   m_adr, m_sel        master address and byte selects
//   m_dat_i / m_dat_o   master write data in / read data out
//   m_ack, m_err        master acknowledge / bus error (never both set)
//   s_cyc, s_stb        per-slot cycle / strobe (one-hot or zero)
//   s_we, s_adr, s_sel, s_dat_o   broadcast copies of the master signals
//   s_dat_i             per-slot read data, slot n at [32n+31:32n]
//   s_ack, s_err        per-slot acknowledge / error
//   bus_error           one-cycle pulse per terminated cycle
//   err_addr, err_cause address and cause of the last terminated cycle
//                       (cause: 0 none, 1 unpopulated, 2 timeout, 3 slave err)
// -----------------------------------------------------------------------------
module wb_bus_decoder #(
    parameter int unsigned BASE = 28,
    parameter int unsigned SELW = 4,
    localparam int unsigned NPORTS = 2 ** SELW,
    parameter logic [NPORTS-1:0] PORTMASK = 16'hffff,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   m_cyc,
    input  logic                   m_stb,
    input  logic                   m_we,
    input  logic [31:0]            m_adr,
    input  logic [3:0]             m_sel,
    input  logic [31:0]            m_dat_i,
    output logic [31:0]            m_dat_o,
    output logic                   m_ack,
    output logic                   m_err,
    output logic [NPORTS-1:0]      s_cyc,
    output logic [NPORTS-1:0]      s_stb,
    output logic                   s_we,
    output logic [31:0]            s_adr,
    output logic [3:0]             s_sel,
    output logic [31:0]            s_dat_o,
    input  logic [NPORTS*32-1:0]   s_dat_i,
    input  logic [NPORTS-1:0]      s_ack,
    input  logic [NPORTS-1:0]      s_err,
    output logic                   bus_error,
    output logic [31:0]            err_addr,
    output logic [1:0]             err_cause
`ifdef WB_DECODER_STATS_EN
    ,
    output logic [15:0]            err_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_UNPOP   = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
    localparam logic [1:0] CAUSE_SLVERR  = 2'd3;

    // Stall count at which an un-acked strobe is aborted.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    // True when the given slot has a slave behind it.
    function automatic logic slot_populated(input logic [SELW-1:0] slot);
        return PORTMASK[slot];
    endfunction

    state_e              state_q, state_d;
    logic [SELW-1:0]     slot_q, slot_d;
    logic [15:0]         tcnt_q, tcnt_d;
    logic                bus_error_q, bus_error_d;
    logic [31:0]         err_addr_q, err_addr_d;
    logic [1:0]          err_cause_q, err_cause_d;

    logic [SELW-1:0]     sel_field_s;
    logic                slot_ack_s;
    logic                slot_err_s;
    logic [31:0]         slot_dat_s;

    assign sel_field_s = m_adr[BASE +: SELW];
    assign slot_ack_s  = s_ack[slot_q];
    assign slot_err_s  = s_err[slot_q];
    // Slot n's read data starts at bit 32*n; concatenating five zero bits
    // forms that offset without a multiplier.
    assign slot_dat_s  = s_dat_i[{slot_q, 5'd0} +: 32];

    // Broadcast copies of the master request towards every slave.
    assign s_we    = m_we;
    assign s_adr   = m_adr;
    assign s_sel   = m_sel;
    assign s_dat_o = m_dat_i;

    assign bus_error = bus_error_q;
    assign err_addr  = err_addr_q;
    assign err_cause = err_cause_q;

    // Next-state logic: decode, watchdog and error capture.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        tcnt_d      = tcnt_q;
        bus_error_d = 1'b0;
        err_addr_d  = err_addr_q;
        err_cause_d = err_cause_q;

        case (state_q)
            ST_IDLE: begin
                if (m_cyc && m_stb) begin
                    slot_d = sel_field_s;
                    tcnt_d = 16'd0;
                    if (slot_populated(sel_field_s)) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d     = ST_ERR;
                        bus_error_d = 1'b1;
                        err_addr_d  = m_adr;
                        err_cause_d = CAUSE_UNPOP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACTIVE: begin
                if (!m_cyc) begin
                    state_d = ST_IDLE;
                end else if (slot_err_s) begin
                    // m_err was already given combinationally this cycle, so
                    // skip ST_ERR (it would repeat m_err) and go straight to drain.
                    state_d     = ST_DRAIN;
                    bus_error_d = 1'b1;
                    err_addr_d  = m_adr;
                    err_cause_d = CAUSE_SLVERR;
                end else if (slot_ack_s) begin
                    // An ack in the last allowed cycle still wins over the timeout.
                    tcnt_d = 16'd0;
                end else if (m_stb) begin
                    if (tcnt_q == TO_LAST) begin
                        state_d     = ST_ERR;
                        bus_error_d = 1'b1;
                        err_addr_d  = m_adr;
                        err_cause_d = CAUSE_TIMEOUT;
                    end else begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                end else begin
                    // Idle beat inside a block cycle: watchdog holds.
                    tcnt_d = tcnt_q;
                end
            end

            ST_ERR: begin
                state_d = ST_DRAIN;
            end

            ST_DRAIN: begin
                if (!m_cyc) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: slave selects and master responses from the current state.
    always_comb begin
        s_cyc   = '0;
        s_stb   = '0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_dat_o = 32'd0;

        case (state_q)
            ST_ACTIVE: begin
                s_cyc[slot_q] = m_cyc;
                s_stb[slot_q] = m_stb;
                // Error takes priority so ack and err are never both seen.
                m_err   = m_cyc & slot_err_s;
                m_ack   = m_cyc & slot_ack_s & ~slot_err_s;
                m_dat_o = slot_dat_s;
            end
            ST_ERR: begin
                m_err = 1'b1;
            end
            default: begin
                m_err = 1'b0;
            end
        endcase
    end

    // State, slot, watchdog and error-capture registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            tcnt_q      <= 16'd0;
            bus_error_q <= 1'b0;
            err_addr_q  <= 32'd0;
            err_cause_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            tcnt_q      <= tcnt_d;
            bus_error_q <= bus_error_d;
            err_addr_q  <= err_addr_d;
            err_cause_q <= err_cause_d;
        end
    end

`ifdef WB_DECODER_STATS_EN
    logic [15:0] err_count_q, err_count_d;

    // Saturating error counter, stepped together with the bus_error pulse.
    always_comb begin
        err_count_d = err_count_q;
        if (bus_error_d && (err_count_q != 16'hffff)) begin
            err_count_d = err_count_q + 16'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_count_q <= 16'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Bench for wb_bus_decoder with slots 0..7 populated and an 8-cycle watchdog.
// Transactions are described as {address, slave response, response delay};
// the expected outcome and the cycle it appears in are derived from the
// protocol rules (decode gap, ack-before-timeout, unpopulated slots).
module tb_wb_bus_decoder;

    localparam int          TO    = 8;
    localparam logic [15:0] MASK  = 16'h00ff;
    localparam int          K_ACK = 0;
    localparam int          K_ERR = 1;
    localparam int          K_NONE = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m_cyc, m_stb, m_we;
    logic [31:0]   m_adr;
    logic [3:0]    m_sel;
    logic [31:0]   m_dat_i;
    logic [31:0]   m_dat_o;
    logic          m_ack, m_err;
    logic [15:0]   s_cyc, s_stb;
    logic          s_we;
    logic [31:0]   s_adr;
    logic [3:0]    s_sel;
    logic [31:0]   s_dat_o;
    logic [511:0]  s_dat_i;
    logic [15:0]   s_ack, s_err;
    logic          bus_error;
    logic [31:0]   err_addr;
    logic [1:0]    err_cause;
`ifdef WB_DECODER_STATS_EN
    logic [15:0]   err_count;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int exp_errs = 0;
    logic [31:0] dat_v [16];
    logic [15:0] mask_v = MASK;

    wb_bus_decoder #(
        .BASE(28), .SELW(4), .PORTMASK(16'h00ff), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
        .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
        .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack), .s_err(s_err),
        .bus_error(bus_error), .err_addr(err_addr), .err_cause(err_cause)
`ifdef WB_DECODER_STATS_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] adr;
        int          kind;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // One complete master cycle against a slave that answers 'kind' on its
    // 'lat'-th strobed cycle (0 = first). Outcome from the protocol rules.
    task automatic run_txn(input logic [31:0] adr, input int kind, input int lat);
        int slot;
        int end_idx;
        int outcome;
        logic [15:0] one_hot;
        slot    = int'(adr[31:28]);
        one_hot = 16'h0001 << slot;
        m_adr = adr; m_cyc = 1'b1; m_stb = 1'b1;
        m_we = 1'($urandom_range(0, 1)); m_sel = 4'($urandom); m_dat_i = $urandom;
        s_ack = '0; s_err = '0;
        @(negedge clk_i);
        chk("decode_gap_stb", 32'(s_stb), 32'd0);
        chk("copy_adr", s_adr, adr);
        next_cycle();
        if (!mask_v[slot]) begin
            @(negedge clk_i);
            chk("unpop_merr", 32'(m_err), 32'd1);
            chk("unpop_ack", 32'(m_ack), 32'd0);
            chk("unpop_buserr", 32'(bus_error), 32'd1);
            chk("unpop_cause", 32'(err_cause), 32'd1);
            chk("unpop_addr", err_addr, adr);
            chk("unpop_scyc", 32'(s_cyc), 32'd0);
            exp_errs++;
            next_cycle();
        end else begin
            if (kind != K_NONE && lat <= TO - 1) begin
                end_idx = lat; outcome = kind;
            end else begin
                end_idx = TO; outcome = K_NONE;
            end
            for (int i = 0; i <= end_idx; i++) begin
                s_ack = '0; s_err = '0;
                if (i == lat && kind == K_ACK) s_ack[slot] = 1'b1;
                if (i == lat && kind == K_ERR) s_err[slot] = 1'b1;
                @(negedge clk_i);
                if (i < end_idx) begin
                    chk("act_stb", 32'(s_stb), 32'(one_hot));
                    chk("act_ack", 32'(m_ack), 32'd0);
                    chk("act_err", 32'(m_err), 32'd0);
                end else if (outcome == K_ACK) begin
                    chk("ack_ack", 32'(m_ack), 32'd1);
                    chk("ack_dat", m_dat_o, dat_v[slot]);
                    chk("ack_err", 32'(m_err), 32'd0);
                    chk("ack_stb", 32'(s_stb), 32'(one_hot));
                end else if (outcome == K_ERR) begin
                    chk("serr_merr", 32'(m_err), 32'd1);
                    chk("serr_ack", 32'(m_ack), 32'd0);
                    chk("serr_pulse_early", 32'(bus_error), 32'd0);
                end else begin
                    chk("to_merr", 32'(m_err), 32'd1);
                    chk("to_ack", 32'(m_ack), 32'd0);
                    chk("to_scyc", 32'(s_cyc), 32'd0);
                    chk("to_buserr", 32'(bus_error), 32'd1);
                    chk("to_cause", 32'(err_cause), 32'd2);
                    chk("to_addr", err_addr, adr);
                end
                next_cycle();
            end
            s_ack = '0; s_err = '0;
            if (outcome != K_ACK) exp_errs++;
            if (outcome == K_ERR) begin
                @(negedge clk_i);
                chk("serr_buserr", 32'(bus_error), 32'd1);
                chk("serr_cause", 32'(err_cause), 32'd3);
                chk("serr_addr", err_addr, adr);
                chk("serr_merr_once", 32'(m_err), 32'd0);
                next_cycle();
            end
        end
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk_i);
        chk("post_scyc", 32'(s_cyc), 32'd0);
        chk("post_ack", 32'(m_ack), 32'd0);
        chk("post_err", 32'(m_err), 32'd0);
        chk("post_buserr", 32'(bus_error), 32'd0);
        next_cycle();
        @(negedge clk_i);
        chk("idle_dat", m_dat_o, 32'd0);
        next_cycle();
    endtask

    initial begin
        vec_t vecs [9];
        int acks;

        vecs[0] = '{32'h3000_0010, K_ACK,  1};
        vecs[1] = '{32'h9000_0000, K_ACK,  0};
        vecs[2] = '{32'h5000_0004, K_NONE, 0};
        vecs[3] = '{32'h7000_0008, K_ERR,  2};
        vecs[4] = '{32'h6000_0000, K_ACK,  7};
        vecs[5] = '{32'h1000_0000, K_ACK,  8};
        vecs[6] = '{32'h4000_0000, K_ERR,  0};
        vecs[7] = '{32'hf000_0000, K_NONE, 0};
        vecs[8] = '{32'h2000_0000, K_ACK,  0};

        for (int i = 0; i < 16; i++) begin
            dat_v[i] = $urandom | 32'h0000_0001;
            s_dat_i[32*i +: 32] = dat_v[i];
        end
        dat_v[3] = 32'hdeadbeef;
        s_dat_i[96 +: 32] = 32'hdeadbeef;

        rst_i = 1'b1; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        m_adr = 32'h3000_0000; m_sel = 4'h0; m_dat_i = 32'd0;
        s_ack = '0; s_err = '0;
        next_cycle();
        next_cycle();
        @(negedge clk_i);
        chk("rst_scyc", 32'(s_cyc), 32'd0);
        chk("rst_dat", m_dat_o, 32'd0);
        chk("rst_buserr", 32'(bus_error), 32'd0);
        chk("rst_addr", err_addr, 32'd0);
        chk("rst_cause", 32'(err_cause), 32'd0);
        next_cycle();
        rst_i = 1'b0;
        next_cycle();

        for (int v = 0; v < 9; v++) run_txn(vecs[v].adr, vecs[v].kind, vecs[v].lat);

        // Block write to slot 0; the slot field moves to 3 mid-block and must be ignored.
        m_adr = 32'h0000_0100; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1;
        @(negedge clk_i);
        chk("blk_decode_gap", 32'(s_stb), 32'd0);
        next_cycle();
        acks = 0;
        for (int b = 0; b < 4; b++) begin
            m_stb = 1'b1; s_ack = 16'h0001; m_dat_i = $urandom;
            @(negedge clk_i);
            chk("blk_stb", 32'(s_stb), 32'h1);
            chk("blk_wdat", s_dat_o, m_dat_i);
            chk("blk_err", 32'(m_err), 32'd0);
            if (m_ack) acks++;
            next_cycle();
            m_stb = 1'b0; s_ack = '0; m_adr = 32'h3000_0200 + 32'(b * 4);
            @(negedge clk_i);
            chk("blk_hold", 32'(s_cyc), 32'h1);
            chk("blk_gap_ack", 32'(m_ack), 32'd0);
            next_cycle();
        end
        chk("blk_acks", 32'(acks), 32'd4);
        m_cyc = 1'b0;
        @(negedge clk_i);
        chk("blk_end_scyc", 32'(s_cyc), 32'd0);
        next_cycle();
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h2000_0000;
        @(negedge clk_i);
        chk("blk_next_gap", 32'(s_stb), 32'd0);
        next_cycle();
        s_ack = 16'h0004;
        @(negedge clk_i);
        chk("blk_next_stb", 32'(s_stb), 32'h4);
        chk("blk_next_ack", 32'(m_ack), 32'd1);
        chk("blk_next_dat", m_dat_o, dat_v[2]);
        next_cycle();
        s_ack = '0; m_cyc = 1'b0; m_stb = 1'b0;
        next_cycle();

        // Slave error, then the master keeps m_cyc high and strobes again.
        m_adr = 32'h7000_0000; m_cyc = 1'b1; m_stb = 1'b1;
        next_cycle();
        s_err = 16'h0080;
        @(negedge clk_i);
        chk("drn_merr", 32'(m_err), 32'd1);
        next_cycle();
        s_err = '0; m_stb = 1'b0;
        exp_errs++;
        @(negedge clk_i);
        chk("drn_cause", 32'(err_cause), 32'd3);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            m_stb = 1'b1; m_adr = 32'h1000_0000; s_ack = 16'h0082;
            @(negedge clk_i);
            chk("drn_stb", 32'(s_stb), 32'd0);
            chk("drn_ack", 32'(m_ack), 32'd0);
            chk("drn_err", 32'(m_err), 32'd0);
            next_cycle();
        end
        s_ack = '0; m_cyc = 1'b0; m_stb = 1'b0;
        next_cycle();
        run_txn(32'h1000_0000, K_ACK, 0);

        // Reset in the middle of an access to slot 2.
        m_adr = 32'h2000_0000; m_cyc = 1'b1; m_stb = 1'b1;
        next_cycle();
        @(negedge clk_i);
        chk("mid_stb", 32'(s_stb), 32'h4);
        next_cycle();
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        exp_errs = 0;
        @(negedge clk_i);
        chk("mid_rst_stb", 32'(s_stb), 32'd0);
        chk("mid_rst_ack", 32'(m_ack), 32'd0);
        chk("mid_rst_err", 32'(m_err), 32'd0);
        chk("mid_rst_addr", err_addr, 32'd0);
        chk("mid_rst_cause", 32'(err_cause), 32'd0);
        next_cycle();
        s_ack = 16'h0004;
        @(negedge clk_i);
        chk("post_rst_stb", 32'(s_stb), 32'h4);
        chk("post_rst_ack", 32'(m_ack), 32'd1);
        next_cycle();
        s_ack = '0; m_cyc = 1'b0; m_stb = 1'b0;
        next_cycle();

        // Random transactions against the rule-based model.
        for (int r = 0; r < 40; r++) begin
            run_txn({4'($urandom_range(0, 15)), 28'($urandom)},
                    $urandom_range(0, 2), $urandom_range(0, 9));
        end

`ifdef WB_DECODER_STATS_EN
        chk("err_count", 32'(err_count), 32'(exp_errs));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
